// File: rtl/present_encrypt_ctrl_pkg.sv
// Shared constants and state encoding for the PRESENT encryption controller.
package present_pkg;

    localparam int DATA_W     = 64;
    localparam int KEY_W      = 80;
    localparam int ROUNDS_DEF = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } ctrlState_e;

endpackage

// File: rtl/present_encrypt_ctrl_if.sv
// Request/response handshake bundle of the PRESENT encryption controller.
interface present_encrypt_ctrl_if #(
    parameter int REP_W = 8
);
    import present_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pt;
    logic [KEY_W-1:0]  in_key;
    logic [REP_W-1:0]  in_reps;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_ct;

    // Requester side: issues plaintext/key and consumes the ciphertext.
    modport master (
        output in_valid, in_pt, in_key, in_reps, out_ready,
        input  in_ready, out_valid, out_ct
    );

    // Controller side.
    modport slave (
        input  in_valid, in_pt, in_key, in_reps, out_ready,
        output in_ready, out_valid, out_ct
    );

endinterface

// File: rtl/present_encrypt_ctrl.sv
// Sequencing controller for an external PRESENT core: latches a request,
// loads the core, times its rounds, repeats on request and holds the result.
module present_encrypt_ctrl
    import present_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int REP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pt,
    input  logic [KEY_W-1:0]  in_key,
    input  logic [REP_W-1:0]  in_reps,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ct,
    output logic [DATA_W-1:0] core_idat,
    output logic [KEY_W-1:0]  core_key,
    output logic              core_load,
    input  logic [DATA_W-1:0] core_odat,
    input  logic              core_done,
    output logic              trig,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = (ROUNDS < 1) ? 1 : $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS);
    localparam logic [REP_W-1:0] ONE_REP  = REP_W'(1);

    ctrlState_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [REP_W-1:0]  repsLeft_q;
    logic [DATA_W-1:0] pt_q;
    logic [KEY_W-1:0]  key_q;
    logic [DATA_W-1:0] ct_q;
    logic              err_q;
    logic              inReady_q;
    logic              outValid_q;
    logic              coreLoad_q;
    logic              trig_q;
    logic              busy_q;
    logic [REP_W-1:0]  repsIn_d;

    // A zero repetition request still runs the cipher once.
    always_comb begin
        repsIn_d = (in_reps == '0) ? ONE_REP : in_reps;
    end

    // Controller FSM; every output is registered alongside the state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            repsLeft_q <= '0;
            pt_q       <= '0;
            key_q      <= '0;
            ct_q       <= '0;
            err_q      <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            coreLoad_q <= 1'b0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pt_q       <= in_pt;
                        key_q      <= in_key;
                        repsLeft_q <= repsIn_d;
                        state_q    <= LOAD;
                        inReady_q  <= 1'b0;
                        coreLoad_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q    <= RUN;
                    cnt_q      <= '0;
                    coreLoad_q <= 1'b0;
                    trig_q     <= 1'b1;
                end
                RUN: begin
                    if (cnt_q == LAST_CNT) begin
                        if (!core_done) begin
                            err_q <= 1'b1;
                        end
                        trig_q <= 1'b0;
                        if (repsLeft_q > ONE_REP) begin
                            repsLeft_q <= repsLeft_q - ONE_REP;
                            state_q    <= LOAD;
                            coreLoad_q <= 1'b1;
                        end else begin
                            repsLeft_q <= '0;
                            ct_q       <= core_odat;
                            state_q    <= HOLD;
                            outValid_q <= 1'b1;
                        end
                    end else begin
                        if (core_done) begin
                            err_q <= 1'b1;
                        end
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_ct    = ct_q;
    assign core_idat = pt_q;
    assign core_key  = key_q;
    assign core_load = coreLoad_q;
    assign trig      = trig_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_present_encrypt_ctrl.sv
// Self-checking bench for present_encrypt_ctrl with a behavioural PRESENT
// core beside it and a scoreboard of expected ciphertexts and timings.
module tb_present_encrypt_ctrl;

    localparam int ROUNDS   = 31;
    localparam int REP_W    = 8;
    localparam int BASE_LAT = ROUNDS + 3;
    localparam int REP_COST = ROUNDS + 2;

    typedef struct {
        logic [63:0] ct;
        int          readyAt;
        int          reps;
        bit          expErr;
    } job_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] core_idat;
    logic [63:0] core_odat;
    logic [79:0] core_key;
    logic        core_load;
    logic        core_done;
    logic        trig;
    logic        busy;
    logic        err;

    int    checks    = 0;
    int    failures  = 0;
    int    cycleCnt  = 0;
    int    readyMode = 0;
    int    modeSnap  = 0;
    bit    forceDoneLow = 1'b0;
    bit    stickyErr    = 1'b0;
    job_t  expQ[$];
    job_t  popped;

    present_encrypt_ctrl_if #(.REP_W(REP_W)) bus ();

    present_encrypt_ctrl #(.ROUNDS(ROUNDS), .REP_W(REP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_pt     (bus.in_pt),
        .in_key    (bus.in_key),
        .in_reps   (bus.in_reps),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_ct    (bus.out_ct),
        .core_idat (core_idat),
        .core_key  (core_key),
        .core_load (core_load),
        .core_odat (core_odat),
        .core_done (core_done),
        .trig      (trig),
        .busy      (busy),
        .err       (err)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Cycle index used to timestamp acceptance and result presentation.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] sBoxLayer(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = sbox4(s[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] pLayer(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 63; i++) r[(i * 16) % 63] = s[i];
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [79:0] keyUpdate(input logic [79:0] k, input int rc);
        logic [79:0] r;
        logic [4:0]  rcb;
        rcb       = 5'(rc);
        r         = {k[18:0], k[79:19]};
        r[79:76]  = sbox4(r[79:76]);
        r[19:15]  = r[19:15] ^ rcb;
        return r;
    endfunction

    // Whole-cipher reference: 31 rounds then the final round-key add.
    function automatic logic [63:0] presentEncrypt(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= ROUNDS; r++) begin
            s = pLayer(sBoxLayer(s ^ k[79:16]));
            k = keyUpdate(k, r);
        end
        return s ^ k[79:16];
    endfunction

    // Behavioural PRESENT core: one round per clock after a load, done when
    // no rounds remain; it is not reset and simply idles at done.
    logic [63:0] coreState = '0;
    logic [79:0] coreKey   = '0;
    int          coreCnt   = 0;
    int          coreRc    = 0;

    always @(posedge clk) begin
        if (core_load) begin
            coreState <= core_idat;
            coreKey   <= core_key;
            coreCnt   <= ROUNDS;
            coreRc    <= 1;
        end else if (coreCnt > 0) begin
            coreState <= pLayer(sBoxLayer(coreState ^ coreKey[79:16]));
            coreKey   <= keyUpdate(coreKey, coreRc);
            coreCnt   <= coreCnt - 1;
            coreRc    <= coreRc + 1;
        end
    end

    assign core_odat = coreState ^ coreKey[79:16];
    assign core_done = (coreCnt == 0) && !forceDoneLow;

    // Consumer back-pressure: always ready, random, or held off.
    always @(posedge clk) begin
        modeSnap = readyMode;
        #1;
        case (modeSnap)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: tracks trig windows and core loads per job, checks latency
    // when a result appears and the ciphertext when it is handed over.
    int trigRun = 0, gapLen = 0, windowsInJob = 0, trigTotal = 0, loadTotal = 0;
    bit prevTrig = 1'b0, prevOutValid = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            trigRun      = 0;
            gapLen       = 0;
            windowsInJob = 0;
            trigTotal    = 0;
            loadTotal    = 0;
            prevTrig     = 1'b0;
            prevOutValid = 1'b0;
        end else begin
            if (core_load) loadTotal++;
            if (trig) begin
                if (!prevTrig && windowsInJob > 0) checkOutput("trig_gap", 80'(gapLen), 80'(1));
                trigRun++;
                trigTotal++;
            end else begin
                if (prevTrig) begin
                    checkOutput("trig_window", 80'(trigRun), 80'(ROUNDS + 1));
                    windowsInJob++;
                    trigRun = 0;
                    gapLen  = 0;
                end
                gapLen++;
            end
            if (bus.out_valid && !prevOutValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_out_valid", 80'(bus.out_valid), 80'(0));
                end else begin
                    checkOutput("latency", 80'(cycleCnt), 80'(expQ[0].readyAt));
                    checkOutput("trig_cycles", 80'(trigTotal), 80'(expQ[0].reps * (ROUNDS + 1)));
                    checkOutput("load_count", 80'(loadTotal), 80'(expQ[0].reps));
                    checkOutput("err_flag", 80'(err), 80'(expQ[0].expErr));
                end
            end
            if (bus.out_valid && bus.out_ready && expQ.size() > 0) begin
                popped = expQ.pop_front();
                checkOutput("ciphertext", 80'(bus.out_ct), 80'(popped.ct));
                trigTotal    = 0;
                loadTotal    = 0;
                windowsInJob = 0;
            end
            prevTrig     = trig;
            prevOutValid = bus.out_valid;
        end
    end

    task automatic applyStimulus(input logic [63:0] pt, input logic [79:0] key,
                                 input logic [REP_W-1:0] reps, input logic [63:0] expCt,
                                 output int acceptAt);
        int   waited;
        int   effReps;
        job_t j;
        waited   = 0;
        acceptAt = -1;
        effReps  = (reps == '0) ? 1 : int'(reps);
        @(posedge clk); #1;
        while (!bus.in_ready && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept_timeout", 80'(bus.in_ready), 80'(1));
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_pt    = pt;
        bus.in_key   = key;
        bus.in_reps  = reps;
        acceptAt     = cycleCnt;
        j.ct         = expCt;
        j.readyAt    = cycleCnt + BASE_LAT + REP_COST * (effReps - 1);
        j.reps       = effReps;
        j.expErr     = stickyErr || forceDoneLow;
        expQ.push_back(j);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("core_idat_latched", 80'(core_idat), 80'(pt));
        checkOutput("core_key_latched", core_key, key);
    endtask

    task automatic waitDone();
        int waited;
        waited = 0;
        while ((expQ.size() != 0 || !bus.in_ready) && waited < 600) begin
            @(posedge clk); #1;
            waited++;
        end
        if (expQ.size() != 0) begin
            checkOutput("done_timeout", 80'(expQ.size()), 80'(0));
            expQ.delete();
        end
    endtask

    task automatic resetDut();
        @(posedge clk); #1;
        rst_n = 1'b0;
        expQ.delete();
        stickyErr = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", 80'(bus.in_ready), 80'(1));
        checkOutput("rst_out_valid", 80'(bus.out_valid), 80'(0));
        checkOutput("rst_core_load", 80'(core_load), 80'(0));
        checkOutput("rst_trig", 80'(trig), 80'(0));
        checkOutput("rst_busy", 80'(busy), 80'(0));
        checkOutput("rst_err", 80'(err), 80'(0));
        checkOutput("rst_out_ct", 80'(bus.out_ct), 80'(0));
        checkOutput("rst_core_idat", 80'(core_idat), 80'(0));
        checkOutput("rst_core_key", core_key, 80'(0));
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [79:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed vectors, back-pressure, mid-run reset, error injection, then random traffic.
    initial begin
        int          acc;
        int          waited;
        logic [63:0] pt;
        logic [79:0] key;
        logic [63:0] holdCt;

        bus.in_valid = 1'b0;
        bus.in_pt    = '0;
        bus.in_key   = '0;
        bus.in_reps  = '0;
        resetDut();

        applyStimulus(64'h0, 80'h0, REP_W'(1), 64'h5579c1387b228445, acc);
        waitDone();
        applyStimulus(64'h0, {80{1'b1}}, REP_W'(1), 64'he72c46c0f5945049, acc);
        waitDone();
        applyStimulus({64{1'b1}}, 80'h0, REP_W'(1), 64'ha112ffc72f68417b, acc);
        waitDone();
        applyStimulus({64{1'b1}}, {80{1'b1}}, REP_W'(3), 64'h3333dcd3213210d2, acc);
        waitDone();

        pt  = rand64();
        key = rand80();
        applyStimulus(pt, key, REP_W'(0), presentEncrypt(pt, key), acc);
        waitDone();

        // Result held under back-pressure while a new request waits.
        readyMode = 2;
        pt     = rand64();
        key    = rand80();
        holdCt = presentEncrypt(pt, key);
        applyStimulus(pt, key, REP_W'(1), holdCt, acc);
        waited = 0;
        while (!bus.out_valid && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("hold_reached", 80'(bus.out_valid), 80'(1));
        bus.in_valid = 1'b1;
        bus.in_pt    = ~pt;
        bus.in_key   = ~key;
        bus.in_reps  = REP_W'(1);
        for (int i = 0; i < 20; i++) begin
            checkOutput("hold_out_valid", 80'(bus.out_valid), 80'(1));
            checkOutput("hold_out_ct", 80'(bus.out_ct), 80'(holdCt));
            checkOutput("hold_in_ready", 80'(bus.in_ready), 80'(0));
            checkOutput("hold_core_load", 80'(core_load), 80'(0));
            @(posedge clk); #1;
        end
        readyMode = 0;
        @(posedge clk); #1;
        checkOutput("release_in_ready", 80'(bus.in_ready), 80'(0));
        pt  = rand64();
        key = rand80();
        applyStimulus(pt, key, REP_W'(2), presentEncrypt(pt, key), acc);
        waitDone();

        // Reset at RUN cnt=10 abandons the job.
        pt  = rand64();
        key = rand80();
        applyStimulus(pt, key, REP_W'(1), presentEncrypt(pt, key), acc);
        while (cycleCnt < acc + 12) begin
            @(posedge clk); #1;
        end
        checkOutput("run_trig_before_reset", 80'(trig), 80'(1));
        rst_n = 1'b0;
        expQ.delete();
        @(posedge clk); #1;
        checkOutput("midrst_trig", 80'(trig), 80'(0));
        checkOutput("midrst_busy", 80'(busy), 80'(0));
        checkOutput("midrst_in_ready", 80'(bus.in_ready), 80'(1));
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        pt  = rand64();
        key = rand80();
        applyStimulus(pt, key, REP_W'(1), presentEncrypt(pt, key), acc);
        waitDone();

        // Missing core_done at capture sets a sticky error.
        forceDoneLow = 1'b1;
        stickyErr    = 1'b1;
        pt  = rand64();
        key = rand80();
        applyStimulus(pt, key, REP_W'(1), presentEncrypt(pt, key), acc);
        waitDone();
        forceDoneLow = 1'b0;
        pt  = rand64();
        key = rand80();
        applyStimulus(pt, key, REP_W'(1), presentEncrypt(pt, key), acc);
        waitDone();
        checkOutput("err_sticky", 80'(err), 80'(1));
        resetDut();

        // Random back-to-back traffic with random consumer stalls.
        readyMode = 1;
        for (int n = 0; n < 10; n++) begin
            pt  = rand64();
            key = rand80();
            applyStimulus(pt, key, REP_W'($urandom_range(0, 3)), presentEncrypt(pt, key), acc);
        end
        waitDone();
        readyMode = 0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
